// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a 2-entry skid buffer and valid/ready flow control
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);
    logic [XLEN-1:0]  imm_new, m_imm, k_imm;
    logic             ill_new, m_ill, k_ill, m_v, k_v;
    logic [TAG_W-1:0] m_tag, k_tag;
    logic             accept, pop, unused;

    assign unused    = ^instr[6:0];
    assign in_ready  = !k_v;
    assign accept    = in_valid && in_ready;
    assign pop       = m_v && out_ready;
    assign out_valid = m_v;
    assign imm_ext   = m_imm;
    assign out_tag   = m_tag;
    assign illegal   = m_ill;

    // decode the immediate for the incoming instruction according to its format
    always_comb begin
        imm_new = '0;
        ill_new = 1'b0;
        case (immSrc)
            3'b000: imm_new = XLEN'($signed(instr[31:20]));
            3'b001: imm_new = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: imm_new = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            3'b011: imm_new = XLEN'($signed({instr[31:12], 12'b0}));
            3'b100: imm_new = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            3'b101: imm_new = XLEN'(instr[19:15]);
            3'b110: imm_new = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            default: ill_new = 1'b1;
        endcase
    end

    // main register M feeds the outputs; skid entry K absorbs one accept while M is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v   <= 1'b0;
            m_imm <= '0;
            m_tag <= '0;
            m_ill <= 1'b0;
            k_v   <= 1'b0;
            k_imm <= '0;
            k_tag <= '0;
            k_ill <= 1'b0;
        end else if (pop) begin
            k_v <= 1'b0;
            if (accept) begin
                m_imm <= imm_new;
                m_tag <= in_tag;
                m_ill <= ill_new;
            end else if (k_v) begin
                m_imm <= k_imm;
                m_tag <= k_tag;
                m_ill <= k_ill;
            end else begin
                m_v <= 1'b0;
            end
        end else if (accept) begin
            if (!m_v) begin
                m_v   <= 1'b1;
                m_imm <= imm_new;
                m_tag <= in_tag;
                m_ill <= ill_new;
            end else begin
                k_v   <= 1'b1;
                k_imm <= imm_new;
                k_tag <= in_tag;
                k_ill <= ill_new;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: random and directed checks of imm_gen_stage at XLEN 32 and 64 against a FIFO reference model
module tb_imm_gen_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  immSrc = '0;
    logic [7:0]  in_tag = '0;
    logic        rdy32, rdy64, ov32, ov64, il32, il64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tg32, tg64;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        logic [7:0]  tag;
        logic        ill;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
        .immSrc(immSrc), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
        .imm_ext(imm32), .out_tag(tg32), .illegal(il32)
    );
    imm_gen_stage #(.XLEN(64), .TAG_W(8)) d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .instr(instr),
        .immSrc(immSrc), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
        .imm_ext(imm64), .out_tag(tg64), .illegal(il64)
    );

    task chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] src, input int xlen);
        longint v;
        case (src)
            3'd0: v = longint'(in[31:20]) - (in[31] ? 64'd4096 : 64'd0);
            3'd1: v = longint'(in[31:25]) * 32 + longint'(in[11:7]) - (in[31] ? 64'd4096 : 64'd0);
            3'd2: v = longint'(in[7]) * 2048 + longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2
                      - (in[31] ? 64'd4096 : 64'd0);
            3'd3: v = longint'(in[31:12]) * 4096 - (in[31] ? 64'h1_0000_0000 : 64'd0);
            3'd4: v = longint'(in[19:12]) * 4096 + longint'(in[20]) * 2048 + longint'(in[30:21]) * 2
                      - (in[31] ? 64'h10_0000 : 64'd0);
            3'd5: v = longint'(in[19:15]);
            3'd6: v = (xlen == 64) ? longint'(in[25:20]) : longint'(in[24:20]);
            default: v = 0;
        endcase
        return (xlen == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    task model_check;
        chk("in_ready32", rdy32, q.size() < 2);
        chk("in_ready64", rdy64, q.size() < 2);
        chk("out_valid32", ov32, q.size() > 0);
        chk("out_valid64", ov64, q.size() > 0);
        if (q.size() > 0) begin
            chk("imm32", imm32, q[0].e32);
            chk("imm64", imm64, q[0].e64);
            chk("tag32", tg32, q[0].tag);
            chk("tag64", tg64, q[0].tag);
            chk("ill32", il32, q[0].ill);
            chk("ill64", il64, q[0].ill);
        end
    endtask

    task cyc(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [7:0] t, input logic r);
        ent_t e;
        logic acc, pop;
        @(negedge clk);
        in_valid = v; instr = ins; immSrc = src; in_tag = t; out_ready = r;
        model_check();
        @(posedge clk);
        acc = v && q.size() < 2;
        pop = r && q.size() > 0;
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.e32 = ref_imm(ins, src, 32);
            e.e64 = ref_imm(ins, src, 64);
            e.tag = t;
            e.ill = (src == 3'd7);
            q.push_back(e);
        end
        #1;
    endtask

    task one(input string name, input logic [31:0] ins, input logic [2:0] src,
             input logic [31:0] e32, input logic [63:0] e64, input logic ill);
        cyc(1'b1, ins, src, 8'hA5, 1'b1);
        chk({name, "_valid"}, ov32, 1'b1);
        chk({name, "_32"}, imm32, e32);
        chk({name, "_64"}, imm64, e64);
        chk({name, "_ill"}, il64, ill);
    endtask

    initial begin
        #2;
        chk("rst_ov_async", ov32, 1'b0);
        chk("rst_imm_async", imm64, 64'd0);
        #10;
        chk("rst_ready", rdy32, 1'b1);
        chk("rst_tag", tg32, 8'd0);
        chk("rst_ill", il32, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        one("i", 32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        one("s", 32'hFE512E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        one("b", 32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        one("j", 32'hFF9FF06F, 3'd4, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        one("csr", 32'h000F8073, 3'd5, 32'h0000001F, 64'h1F, 1'b0);
        one("u1", 32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0);
        one("u2", 32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        one("sh", 32'h03F0D093, 3'd6, 32'h0000001F, 64'h3F, 1'b0);
        one("bad", 32'hDEADBEEF, 3'd7, 32'h0, 64'h0, 1'b1);
        one("aft", 32'h00100093, 3'd0, 32'h1, 64'h1, 1'b0);
        cyc(1'b0, '0, 3'd0, 8'h00, 1'b1);
        // backpressure: third offer must stall and outputs must hold
        cyc(1'b1, 32'h00500093, 3'd0, 8'h01, 1'b0);
        cyc(1'b1, 32'h00600093, 3'd0, 8'h02, 1'b0);
        cyc(1'b1, 32'h00700093, 3'd0, 8'h03, 1'b0);
        chk("bp_ready", rdy32, 1'b0);
        chk("bp_hold_tag", tg32, 8'h01);
        cyc(1'b1, 32'h00700093, 3'd0, 8'h03, 1'b0);
        chk("bp_hold_imm", imm64, 64'h5);
        cyc(1'b1, 32'h00700093, 3'd0, 8'h03, 1'b1);
        chk("bp_pop2", tg32, 8'h02);
        cyc(1'b1, 32'h00700093, 3'd0, 8'h03, 1'b1);
        chk("bp_pop3", tg64, 8'h03);
        chk("bp_imm3", imm32, 32'h7);
        cyc(1'b0, '0, 3'd0, 8'h00, 1'b1);
        chk("bp_empty", ov32, 1'b0);
        // asynchronous reset with two entries held
        cyc(1'b1, 32'hFFF00093, 3'd0, 8'h11, 1'b0);
        cyc(1'b1, 32'hFFF00093, 3'd0, 8'h12, 1'b0);
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", ov64, 1'b0);
        chk("arst_imm32", imm32, 32'h0);
        chk("arst_imm64", imm64, 64'h0);
        chk("arst_tag", tg32, 8'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h02A00093, 3'd0, 8'h55, 1'b1);
        chk("post_rst_tag", tg32, 8'h55);
        chk("post_rst_imm", imm64, 64'h2A);
        cyc(1'b0, '0, 3'd0, 8'h00, 1'b1);
        chk("post_rst_nostale", ov32, 1'b0);
        // randomized traffic
        for (int i = 0; i < 500; i++)
            cyc(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), 8'($urandom),
                1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, 3'd0, 8'h00, 1'b1);
        model_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
